// File: rtl/arb_mux_rr.sv
// Registered N-channel valid/ready multiplexer. Selection is either round-robin
// over requesting channels or a forced channel index; the winner lands in a one-entry output register.
module arb_mux_rr_lane #(
  parameter int SEL_W = 3,
  parameter int IDX   = 0
) (
  input  logic             valid,
  input  logic             force_en,
  input  logic [SEL_W-1:0] force_sel,
  input  logic [SEL_W-1:0] ptr,
  input  logic             xfer,
  input  logic [SEL_W-1:0] gnt,
  output logic             req,
  output logic             upper,
  output logic             ready
);
  localparam logic [SEL_W-1:0] ME = SEL_W'(IDX);

  // In forced mode only the lane matching force_sel may request.
  assign req   = valid && (!force_en || force_sel == ME);
  // Lanes above ptr are searched first, so the search starts at ptr+1.
  assign upper = ME > ptr;
  assign ready = xfer && (gnt == ME);
endmodule

module arb_mux_rr #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 8,
  parameter int SEL_W    = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      force_en,
  input  logic [SEL_W-1:0]          force_sel,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_sel,
  input  logic                      out_ready
);
  logic [CHANNELS-1:0][WIDTH-1:0] data_a;
  logic [CHANNELS-1:0]            req, upper, req_hi;
  logic [SEL_W-1:0]               ptr, gnt, gnt_lo, gnt_hi;
  logic                           gnt_vld, slot_free, xfer;
  logic [WIDTH-1:0]               sel_data;

  assign data_a = in_data;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    arb_mux_rr_lane #(.SEL_W(SEL_W), .IDX(i)) u_lane (
      .valid     (in_valid[i]),
      .force_en  (force_en),
      .force_sel (force_sel),
      .ptr       (ptr),
      .xfer      (xfer),
      .gnt       (gnt),
      .req       (req[i]),
      .upper     (upper[i]),
      .ready     (in_ready[i])
    );
  end

  assign req_hi = req & upper;

  // Two-pass priority: lowest requester above ptr, else lowest overall (the wrap).
  always_comb begin
    gnt_lo = '0;
    gnt_hi = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (req[i])    gnt_lo = SEL_W'(i);
      if (req_hi[i]) gnt_hi = SEL_W'(i);
    end
    gnt     = (|req_hi) ? gnt_hi : gnt_lo;
    gnt_vld = |req;
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < CHANNELS; i++)
      if (gnt == SEL_W'(i)) sel_data = data_a[i];
  end

  assign slot_free = !out_valid || out_ready;
  assign xfer      = slot_free && gnt_vld && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= SEL_W'(CHANNELS - 1);
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_sel   <= gnt;
      ptr       <= gnt;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_arb_mux_rr.sv
// Scoreboard bench for arb_mux_rr: expected beats are queued as stimulus is
// driven and popped when the output register presents a new beat.
module tb_arb_mux_rr;
  localparam int W = 16;
  localparam int N = 8;
  localparam int S = 3;

  typedef struct packed {
    logic [S-1:0] sel;
    logic [W-1:0] data;
  } beat_t;

  logic             clk = 1'b0;
  logic             reset;
  logic [N-1:0]     in_valid;
  logic [N*W-1:0]   in_data;
  logic [N-1:0]     in_ready;
  logic             force_en;
  logic [S-1:0]     force_sel;
  logic             out_valid;
  logic [W-1:0]     out_data;
  logic [S-1:0]     out_sel;
  logic             out_ready;

  logic [5:0]       in_valid6;
  logic [6*W-1:0]   in_data6;
  logic [5:0]       in_ready6;
  logic             force_en6;
  logic [S-1:0]     force_sel6;
  logic             out_valid6;
  logic [W-1:0]     out_data6;
  logic [S-1:0]     out_sel6;

  logic [N-1:0]     rdy;
  logic [5:0]       rdy6;
  beat_t            q[$];
  beat_t            e;
  int               errors = 0;
  int               checks = 0;

  always #5 clk = ~clk;

  arb_mux_rr #(.WIDTH(W), .CHANNELS(N), .SEL_W(S)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .force_en(force_en), .force_sel(force_sel),
    .out_valid(out_valid), .out_data(out_data), .out_sel(out_sel),
    .out_ready(out_ready)
  );

  arb_mux_rr #(.WIDTH(W), .CHANNELS(6), .SEL_W(S)) dut6 (
    .clk(clk), .reset(reset), .in_valid(in_valid6), .in_data(in_data6),
    .in_ready(in_ready6), .force_en(force_en6), .force_sel(force_sel6),
    .out_valid(out_valid6), .out_data(out_data6), .out_sel(out_sel6),
    .out_ready(1'b1)
  );

  // Capture combinational in_ready before the edge, then step past it.
  task automatic tick();
    #1;
    rdy  = in_ready;
    rdy6 = in_ready6;
    @(posedge clk);
    #1;
  endtask

  function automatic beat_t sb_pop();
    beat_t b;
    b = 'x;
    if (q.size() != 0) b = q.pop_front();
    return b;
  endfunction

  function automatic beat_t mk(input int ch);
    beat_t b;
    b.sel  = S'(ch);
    b.data = W'(16'h1000 + ch);
    return b;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    q.delete();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    in_valid = '1;
    out_ready = 1'b1;
    do_reset();
    checks++;
    if (rdy !== '0) begin errors++; $display("FAIL reset_in_ready got=%b want=0", rdy); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++;
    if (out_sel !== '0 || out_data !== '0)
      begin errors++; $display("FAIL reset_out_regs sel=%0d data=%h want 0/0", out_sel, out_data); end
    checks++;
    if (out_valid6 !== 1'b0) begin errors++; $display("FAIL reset_out_valid6 got=%b want=0", out_valid6); end
    in_valid = '0;
    tick();
  endtask

  task automatic test_rr_all();
    do_reset();
    in_valid = 8'hFF; out_ready = 1'b1; force_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      q.push_back(mk(i % N));
      tick();
      checks++;
      if (rdy !== N'(1 << (i % N)))
        begin errors++; $display("FAIL rr_ready[%0d] got=%b want=%b", i, rdy, N'(1 << (i % N))); end
      e = sb_pop();
      checks++;
      if (out_valid !== 1'b1 || out_sel !== e.sel || out_data !== e.data)
        begin errors++; $display("FAIL rr_beat[%0d] v=%b sel=%0d data=%h want sel=%0d data=%h", i, out_valid, out_sel, out_data, e.sel, e.data); end
    end
    in_valid = '0;
    tick();
  endtask

  task automatic test_sparse();
    int exp_ch [4] = '{2, 5, 2, 5};
    do_reset();
    in_valid = 8'b0010_0100; out_ready = 1'b1; force_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      q.push_back(mk(exp_ch[i]));
      tick();
      e = sb_pop();
      checks++;
      if (out_valid !== 1'b1 || out_sel !== e.sel || out_data !== e.data)
        begin errors++; $display("FAIL sparse_beat[%0d] sel=%0d data=%h want sel=%0d data=%h", i, out_sel, out_data, e.sel, e.data); end
    end
    in_valid = '0;
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 16'h1005 || rdy !== '0)
      begin errors++; $display("FAIL sparse_drain v=%b data=%h rdy=%b want 0/1005/0", out_valid, out_data, rdy); end
  endtask

  task automatic test_stall();
    do_reset();
    force_en = 1'b0; out_ready = 1'b0;
    in_data[3*W +: W] = 16'hBEEF;
    in_valid = 8'b0000_1000;
    q.push_back('{sel: 3'd3, data: 16'hBEEF});
    tick();
    e = sb_pop();
    checks++;
    if (out_valid !== 1'b1 || out_sel !== e.sel || out_data !== e.data)
      begin errors++; $display("FAIL stall_load sel=%0d data=%h want sel=%0d data=%h", out_sel, out_data, e.sel, e.data); end
    in_valid = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (rdy !== '0 || out_valid !== 1'b1 || out_sel !== 3'd3 || out_data !== 16'hBEEF)
        begin errors++; $display("FAIL stall_hold[%0d] rdy=%b v=%b sel=%0d data=%h want 0/1/3/beef", i, rdy, out_valid, out_sel, out_data); end
    end
    in_data[3*W +: W] = 16'h1003;
    out_ready = 1'b1;
    q.push_back(mk(4));
    tick();
    e = sb_pop();
    checks++;
    if (rdy !== 8'b0001_0000 || out_sel !== e.sel || out_data !== e.data)
      begin errors++; $display("FAIL stall_refill rdy=%b sel=%0d data=%h want rdy=00010000 sel=%0d data=%h", rdy, out_sel, out_data, e.sel, e.data); end
    in_valid = '0;
    tick();
  endtask

  task automatic test_force();
    do_reset();
    out_ready = 1'b1; in_valid = 8'hFF;
    force_en = 1'b1; force_sel = 3'd6;
    for (int i = 0; i < 3; i++) begin
      q.push_back(mk(6));
      tick();
      e = sb_pop();
      checks++;
      if (rdy !== 8'b0100_0000 || out_sel !== e.sel || out_data !== e.data)
        begin errors++; $display("FAIL force_beat[%0d] rdy=%b sel=%0d data=%h want ch6", i, rdy, out_sel, out_data); end
    end
    in_valid = 8'b1011_1111;
    tick();
    checks++;
    if (rdy !== '0 || out_valid !== 1'b0)
      begin errors++; $display("FAIL force_novalid rdy=%b v=%b want 0/0", rdy, out_valid); end
    in_valid = 8'hFF;
    q.push_back(mk(6));
    tick();
    e = sb_pop();
    checks++;
    if (out_sel !== e.sel || out_data !== e.data)
      begin errors++; $display("FAIL force_regrant sel=%0d want=%0d", out_sel, e.sel); end
    force_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      q.push_back(mk(i == 0 ? 7 : 0));
      tick();
      e = sb_pop();
      checks++;
      if (out_valid !== 1'b1 || out_sel !== e.sel || out_data !== e.data)
        begin errors++; $display("FAIL force_switch[%0d] sel=%0d data=%h want sel=%0d data=%h", i, out_sel, out_data, e.sel, e.data); end
    end
    in_valid = '0;
    tick();
  endtask

  task automatic test_force_range6();
    in_valid6 = 6'h3F; force_en6 = 1'b1;
    force_sel6 = 3'd7;
    tick();
    checks++;
    if (rdy6 !== '0 || out_valid6 !== 1'b0)
      begin errors++; $display("FAIL range6_sel7 rdy=%b v=%b want 0/0", rdy6, out_valid6); end
    force_sel6 = 3'd6;
    tick();
    checks++;
    if (rdy6 !== '0 || out_valid6 !== 1'b0)
      begin errors++; $display("FAIL range6_sel6 rdy=%b v=%b want 0/0", rdy6, out_valid6); end
    force_sel6 = 3'd5;
    tick();
    checks++;
    if (rdy6 !== 6'b10_0000 || out_valid6 !== 1'b1 || out_sel6 !== 3'd5 || out_data6 !== 16'h2005)
      begin errors++; $display("FAIL range6_sel5 rdy=%b v=%b sel=%0d data=%h want 100000/1/5/2005", rdy6, out_valid6, out_sel6, out_data6); end
    in_valid6 = '0;
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    force_en = 1'b0; in_valid = 8'hFF; out_ready = 1'b0;
    q.push_back(mk(0));
    tick();
    e = sb_pop();
    checks++;
    if (out_valid !== 1'b1 || out_sel !== e.sel)
      begin errors++; $display("FAIL mid_setup v=%b sel=%0d want 1/%0d", out_valid, out_sel, e.sel); end
    tick();
    do_reset();
    checks++;
    if (out_valid !== 1'b0 || out_sel !== '0 || out_data !== '0)
      begin errors++; $display("FAIL mid_reset v=%b sel=%0d data=%h want 0/0/0", out_valid, out_sel, out_data); end
    out_ready = 1'b1;
    q.push_back(mk(0));
    tick();
    e = sb_pop();
    checks++;
    if (out_valid !== 1'b1 || out_sel !== e.sel || out_data !== e.data)
      begin errors++; $display("FAIL mid_first sel=%0d data=%h want sel=%0d data=%h", out_sel, out_data, e.sel, e.data); end
    in_valid = '0;
    tick();
  endtask

  initial begin
    reset = 1'b1; in_valid = '0; out_ready = 1'b0; force_en = 1'b0; force_sel = '0;
    in_valid6 = '0; force_en6 = 1'b0; force_sel6 = '0;
    for (int i = 0; i < N; i++) in_data[i*W +: W] = W'(16'h1000 + i);
    for (int i = 0; i < 6; i++) in_data6[i*W +: W] = W'(16'h2000 + i);
    @(posedge clk);
    #1;
    test_reset();
    test_rr_all();
    test_sparse();
    test_stall();
    test_force();
    test_force_range6();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/arb_mux_rr.md
Name: arb_mux_rr

Overview:
- Parametrised, registered N-channel data multiplexer with valid/ready handshakes on every input and on the output.
- Select is either a round-robin arbiter over requesting channels or a forced channel index (direct-select mode).
- The selected beat is captured in a one-entry output register.
- Used where several datapath sources (ALU, MDR, PC adder, shifter, ...) contend for one bus and the plain combinational selector is insufficient.

Parameters:
- WIDTH, 16, data width per channel in bits.
- CHANNELS, 8, number of input channels (2..16).
- SEL_W, 3, width of channel index; must equal ceil(log2(CHANNELS)).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  CHANNELS  per-channel request; bit i = channel i has a beat.
- in_data  input  CHANNELS*WIDTH  packed data; channel i at bits [i*WIDTH +: WIDTH].
- in_ready  output  CHANNELS  per-channel accept; at most one bit set per cycle.
- force_en  input  1  1 = direct-select mode, 0 = round-robin mode.
- force_sel  input  SEL_W  channel index used when force_en=1.
- out_valid  output  1  output register holds a beat.
- out_data  output  WIDTH  registered data of the held beat.
- out_sel  output  SEL_W  channel index the held beat came from.
- out_ready  input  1  downstream accepts the held beat.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset), sampled on the rising edge of clk.
- Reset values: out_valid=0, out_data=0, out_sel=0, rr pointer ptr=CHANNELS-1 (so channel 0 has highest priority after reset). in_ready is combinational and evaluates to 0 during the reset cycle.
- Slot free: slot_free = !out_valid || out_ready (same-cycle drain and refill allowed).
- Grant, round-robin mode (force_en=0): grant is the first channel with in_valid set, searching ptr+1, ptr+2, ... wrapping modulo CHANNELS and ending at ptr. No valid bits -> no grant.
- Grant, forced mode (force_en=1): grant = force_sel iff force_sel < CHANNELS and in_valid[force_sel]=1; otherwise no grant. Other channels are never granted in this mode.
- in_ready[i] = slot_free && grant valid && grant==i. in_ready is combinational from in_valid, force_*, out_valid and out_ready. Sources must not make in_valid depend on in_ready.
- Transfer: on a clock edge where in_valid[g] && in_ready[g]:
  - out_data <= channel g data;
  - out_sel <= g;
  - out_valid <= 1;
  - ptr <= g (forced-mode transfers also update ptr).
- Drain without refill (out_valid && out_ready, no grant): out_valid <= 0; out_data and out_sel hold their last values.
- Stall (out_valid && !out_ready): out_data, out_sel and ptr hold; all in_ready=0.
- Latency: one cycle from accepted input to out_valid. Sustained throughput is one beat per cycle while out_ready=1.
- Fairness: with all channels continuously valid in round-robin mode, grant order is 0,1,...,CHANNELS-1,0,... Each channel waits at most CHANNELS-1 transfers.
- Mode switch takes effect the same cycle; ptr is not reset by a mode switch.
- Reset mid-operation: a held beat is discarded (out_valid=0 on the next cycle) and ptr returns to CHANNELS-1, regardless of out_ready.
- Widths: no arithmetic on data. ptr+k wrap is computed modulo CHANNELS, not modulo 2^SEL_W; indices >= CHANNELS are never produced.

Test Plan:
- Reset, then in_valid=8'hFF, channel i data = 16'h1000+i, out_ready=1, force_en=0 for 10 cycles -> out_sel sequence 0,1,2,...,7,0,1; out_data 16'h1000..16'h1007,16'h1000,16'h1001; exactly one in_ready bit per cycle.
- in_valid=8'b0010_0100, out_ready=1, ptr after reset -> grants 2,5,2,5; then drop in_valid to 0 -> out_valid falls one cycle after the last grant, out_data holds last value.
- Hold beat from channel 3 (data 16'hBEEF) with out_ready=0 for 4 cycles while in_valid=8'hFF -> out_data stays 16'hBEEF, out_sel=3, in_ready=0 every cycle. Release out_ready -> same-cycle refill, next out_sel=4.
- force_en=1, force_sel=6, in_valid=8'hFF -> only channel 6 granted every cycle. force_sel=6 with in_valid[6]=0 -> no grant, out_valid falls. With CHANNELS=6, force_sel=7 -> no grant.
- Forced grant of channel 6, then force_en=0 with in_valid=8'hFF -> next grant is 7, then 0.
- Assert reset for one cycle while out_valid=1, out_ready=0 -> next cycle out_valid=0, out_sel=0, out_data=0. The next round-robin grant with in_valid=8'hFF is channel 0.
